buzzer_song_sequencer: RTL and testbench

Plays a stored melody on the buzzer tone generator. It walks a synchronous score ROM of note-frequency/duration words and drives the 12-bit hz input of the buzzer player with per-note timing. It inserts a short silent gap between notes and supports rest notes, pause, stop, looping and an end-of-song marker. It sits between the top-level mode logic (start/stop/pause controls) and the buzzer player, replacing switch-driven hz when song mode is active.

---
 rtl/buzzer_song_sequencer_if.sv | 25 ++
 rtl/buzzer_song_sequencer.sv | 120 ++++++++++++
 tb/tb_buzzer_song_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_song_sequencer_if.sv
// Control and score-ROM bundle between the mode logic, the score ROM and the
// song sequencer; the sequencer takes the slave side.
interface buzzer_song_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [11:0]       hz;
    logic              playing;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, rom_data,
        input  rom_addr, hz, playing, done
    );

    modport slave (
        input  start, stop, pause, loop_en, rom_data,
        output rom_addr, hz, playing, done
    );
endinterface

// File: rtl/buzzer_song_sequencer.sv
// Walks a synchronous score ROM of {hz, duration} words and drives the buzzer
// hz input with per-note timing, inter-note gaps, rests, pause, stop and looping.
module buzzer_song_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int ADDR_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    buzzer_song_sequencer_if.slave  bus
);
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_NOTE, S_GAP, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       note_hz_q, note_hz_d;
    logic [3:0]        unit_q, unit_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [11:0]       hz_q, hz_d;
    logic              done_q, done_d;
    logic              frozen;

    // Pause only bites while a song is in progress; IDLE and DONE ignore it.
    assign frozen = bus.pause && (state_q inside {S_FETCH, S_LOAD, S_NOTE, S_GAP});

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        note_hz_d = note_hz_q;
        unit_d    = unit_q;
        beat_d    = beat_q;
        gap_d     = gap_q;

        if (bus.stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else if (!frozen) begin
            unique case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    if (bus.start) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    note_hz_d = bus.rom_data[15:4];
                    if (bus.rom_data[3:0] == 4'd0) begin
                        addr_d  = '0;
                        state_d = bus.loop_en ? S_FETCH : S_DONE;
                    end else begin
                        unit_d  = bus.rom_data[3:0];
                        beat_d  = BEAT_LAST;
                        state_d = S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (beat_q != '0) begin
                        beat_d = beat_q - BEAT_W'(1);
                    end else if (unit_q == 4'd1) begin
                        gap_d   = GAP_LAST;
                        state_d = S_GAP;
                    end else begin
                        unit_d = unit_q - 4'd1;
                        beat_d = BEAT_LAST;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        hz_d   = (state_d == S_NOTE) ? note_hz_d : 12'd0;
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            note_hz_q <= '0;
            unit_q    <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            hz_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_hz_q <= note_hz_d;
            unit_q    <= unit_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            hz_q      <= hz_d;
            done_q    <= done_d;
        end
    end

    // hz_q keeps the note while paused so the tone returns on release; the output is muted instead.
    assign bus.hz       = frozen ? 12'd0 : hz_q;
    assign bus.rom_addr = addr_q;
    assign bus.playing  = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_buzzer_song_sequencer.sv
// Scoreboard bench: a flattened per-cycle song timeline predicts every output
// cycle; a negedge monitor pops and compares the predictions.
module tb_buzzer_song_sequencer;
    localparam int BEAT   = 4;
    localparam int GAP    = 2;
    localparam int AW     = 8;
    localparam int TL_MAX = 4000;

    typedef struct packed {
        logic [11:0] hz;
        logic        done;
        logic [7:0]  addr;
    } ent_t;

    typedef struct packed {
        logic [11:0] hz;
        logic        playing;
        logic        done;
        logic [7:0]  addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buzzer_song_sequencer_if #(.ADDR_W(AW)) bus ();

    buzzer_song_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    ent_t tl[$];
    int   pos = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("hz",       32'(bus.hz),       32'(e.hz));
            check("playing",  32'(bus.playing),  32'(e.playing));
            check("done",     32'(bus.done),     32'(e.done));
            check("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
        end
    end

    function automatic ent_t mk(input logic [11:0] hz, input logic d, input logic [7:0] a);
        ent_t e;
        e.hz = hz; e.done = d; e.addr = a;
        return e;
    endfunction

    // Flatten the score into what a song looks like cycle by cycle from its first FETCH.
    task automatic build_timeline(input bit loop_v);
        logic [7:0]  a;
        logic [15:0] w;
        tl.delete();
        a = 8'd0;
        while (tl.size() < TL_MAX) begin
            tl.push_back(mk(12'd0, 1'b0, a));
            tl.push_back(mk(12'd0, 1'b0, a));
            w = rom[a];
            if (w[3:0] == 4'd0) begin
                if (loop_v) begin
                    a = 8'd0;
                end else begin
                    tl.push_back(mk(12'd0, 1'b1, 8'd0));
                    break;
                end
            end else begin
                repeat (int'(w[3:0]) * BEAT) tl.push_back(mk(w[15:4], 1'b0, a));
                repeat (GAP) tl.push_back(mk(12'd0, 1'b0, a));
                a = a + 8'd1;
            end
        end
    endtask

    task automatic model_cycle(input bit st, input bit sp, input bit ps);
        obs_t e;
        if (pos < 0) begin
            e = '0;
        end else begin
            e.hz      = (ps && !tl[pos].done) ? 12'd0 : tl[pos].hz;
            e.playing = 1'b1;
            e.done    = tl[pos].done;
            e.addr    = tl[pos].addr;
        end
        exp_q.push_back(e);
        if (sp)                   pos = -1;
        else if (pos < 0)         pos = st ? 0 : -1;
        else if (tl[pos].done)    pos = -1;
        else if (!ps && pos + 1 < tl.size()) pos++;
    endtask

    // Fixed points of the reference song taken straight from the expected timelines.
    task automatic directed(input int scen, input int c);
        case (scen)
            1: case (c)
                3:  check("s1_hz_c3",   32'(bus.hz), 32'd262);
                10: check("s1_hz_c10",  32'(bus.hz), 32'd262);
                11: check("s1_hz_c11",  32'(bus.hz), 32'd0);
                23: check("s1_hz_c23",  32'(bus.hz), 32'd294);
                26: check("s1_hz_c26",  32'(bus.hz), 32'd294);
                30: check("s1_done_c30", 32'(bus.done), 32'd0);
                31: check("s1_done_c31", 32'(bus.done), 32'd1);
                32: check("s1_play_c32", 32'(bus.playing), 32'd0);
                default: ;
            endcase
            2: case (c)
                5:  check("s2_hz_c5",  32'(bus.hz), 32'd0);
                10: check("s2_hz_c10", 32'(bus.hz), 32'd262);
                15: check("s2_hz_c15", 32'(bus.hz), 32'd262);
                16: check("s2_hz_c16", 32'(bus.hz), 32'd0);
                36: check("s2_done_c36", 32'(bus.done), 32'd1);
                default: ;
            endcase
            3: case (c)
                25: check("s3_play_c25", 32'(bus.playing), 32'd0);
                33: check("s3_hz_c33",   32'(bus.hz), 32'd262);
                default: ;
            endcase
            4: case (c)
                31: check("s4_addr_c31", 32'(bus.rom_addr), 32'd0);
                33: check("s4_hz_c33",   32'(bus.hz), 32'd262);
                default: ;
            endcase
            default: ;
        endcase
    endtask

    task automatic run(input int n, input bit loop_v, input int start_a, input int start_b,
                       input int stop_a, input int p_lo, input int p_hi, input bit rnd,
                       input bit end_stop, input int scen);
        bit st, sp, ps, rp;
        rp = 1'b0;
        build_timeline(loop_v);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            st = (c == start_a) || (c == start_b);
            sp = (c == stop_a) || (end_stop && c == n - 1);
            ps = (c >= p_lo) && (c <= p_hi);
            if (rnd) begin
                if ($urandom_range(0, 9) == 0) rp = !rp;
                ps = ps | rp;
                st = st | ($urandom_range(0, 59) == 0);
                sp = sp | ($urandom_range(0, 299) == 0);
            end
            bus.start   = st;
            bus.stop    = sp;
            bus.pause   = ps;
            bus.loop_en = loop_v;
            model_cycle(st, sp, ps);
            if (scen != 0) begin
                #1;
                directed(scen, c);
            end
        end
    endtask

    task automatic load_reference_rom();
        foreach (rom[i]) rom[i] = 16'h0;
        rom[0] = {12'd262, 4'd2};
        rom[1] = {12'd0,   4'd1};
        rom[2] = {12'd294, 4'd1};
        rom[3] = {12'd0,   4'd0};
    endtask

    task automatic load_random_rom(input bit with_marker);
        int m;
        m = $urandom_range(2, 7);
        foreach (rom[i]) begin
            rom[i][3:0]  = 4'($urandom_range(1, 3));
            rom[i][15:4] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        end
        if (with_marker) rom[m] = {12'($urandom_range(0, 4095)), 4'd0};
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;
        load_reference_rom();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hz",      32'(bus.hz),       32'd0);
        check("reset_playing", 32'(bus.playing),  32'd0);
        check("reset_done",    32'(bus.done),     32'd0);
        check("reset_addr",    32'(bus.rom_addr), 32'd0);
        rst = 1'b0;

        run(36, 1'b0, 0, -1, -1, -1, -1, 1'b0, 1'b1, 1);
        run(42, 1'b0, 0, -1, -1,  5,  9, 1'b0, 1'b1, 2);
        run(40, 1'b0, 0, 30, 24, -1, -1, 1'b0, 1'b1, 3);
        run(45, 1'b1, 0, -1, -1, -1, -1, 1'b0, 1'b1, 4);
        run(6,  1'b0, 0, -1,  0, -1, -1, 1'b0, 1'b1, 0);
        run(36, 1'b0, 0,  6, -1, -1, -1, 1'b0, 1'b1, 1);

        // Asynchronous reset in the middle of the first note.
        run(8, 1'b0, 0, -1, -1, -1, -1, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_hz",      32'(bus.hz),       32'd0);
        check("async_rst_playing", 32'(bus.playing),  32'd0);
        check("async_rst_addr",    32'(bus.rom_addr), 32'd0);
        #1;
        rst = 1'b0;
        pos = -1;
        run(10, 1'b0, -1, -1, -1, -1, -1, 1'b0, 1'b0, 0);
        run(36, 1'b0, 0, -1, -1, -1, -1, 1'b0, 1'b1, 1);

        // Address wrap: no end marker anywhere, all one-unit notes.
        load_random_rom(1'b0);
        foreach (rom[i]) rom[i][3:0] = 4'd1;
        run(2120, 1'b0, 0, -1, -1, -1, -1, 1'b0, 1'b1, 0);

        for (int r = 0; r < 10; r++) begin
            load_random_rom(1'b1);
            run(150, r[0], 0, -1, -1, -1, -1, 1'b1, 1'b1, 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
